// File: rtl/seg_status_display.sv
// seg_status_display: 8-digit multiplexed seven-segment status display with 5 flag LEDs.
// Pages: ALU result, PC/opcode, flags while running; UART load status before start.
// Digit values are snapshotted once per scan frame so a frame never mixes old and new data.
// Optional macro DISPLAY_BLINK_EN blinks the whole display while the shadowed halt is high.
module seg_status_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_cpu,
    input  logic        i_instr_transmit_done,
    input  logic [7:0]  i_max_addr,
    input  logic        i_halt,
    input  logic [15:0] i_alu_result_low,
    input  logic [15:0] i_alu_result_high,
    input  logic [4:0]  i_flags,
    input  logic [7:0]  i_current_opcode,
    input  logic [7:0]  i_current_pc,
    input  logic        i_page_next,
    output logic [7:0]  o_seg_an,
    output logic [7:0]  o_seg_cat,
    output logic [1:0]  o_page,
    output logic [4:0]  o_led_flags
);
    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit;
    logic          scan_wrap;
    logic          frame_wrap;
    logic          snap_pending;
    logic          done_s;
    logic          halt_s;
    logic [7:0]    max_addr_s;
    logic [15:0]   low_s;
    logic [15:0]   high_s;
    logic [4:0]    flags_s;
    logic [7:0]    opcode_s;
    logic [7:0]    pc_s;
    logic [1:0]    run_page;
    logic [1:0]    page_adv;
    logic [3:0]    alu_nib;
    logic [7:0]    flag_bits;
    logic [7:0]    glyph;
    logic          blink_off;

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    assign frame_wrap = scan_wrap && digit == 3'd7;

    // Scan timer: each digit stays selected for SCAN_DIV cycles, digits cycle 0..7.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap)
                digit <= digit + 1'b1;
        end
    end

    // Shadow capture at every frame boundary, plus once right after reset so the first frame is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_pending <= 1'b1;
            done_s       <= 1'b0;
            halt_s       <= 1'b0;
            max_addr_s   <= '0;
            low_s        <= '0;
            high_s       <= '0;
            flags_s      <= '0;
            opcode_s     <= '0;
            pc_s         <= '0;
        end else begin
            snap_pending <= 1'b0;
            if (snap_pending || frame_wrap) begin
                done_s     <= i_instr_transmit_done;
                halt_s     <= i_halt;
                max_addr_s <= i_max_addr;
                low_s      <= i_alu_result_low;
                high_s     <= i_alu_result_high;
                flags_s    <= i_flags;
                opcode_s   <= i_current_opcode;
                pc_s       <= i_current_pc;
            end
        end
    end

    // Next run page: the load page counts as page 0 once the CPU starts.
    always_comb begin
        run_page = o_page == 2'd3 ? 2'd0 : o_page;
        page_adv = !i_page_next ? run_page : run_page == 2'd2 ? 2'd0 : run_page + 2'd1;
    end

    // Page register; a stopped CPU always shows the load page and ignores page pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_page <= 2'd0;
        else
            o_page <= i_start_cpu ? page_adv : 2'd3;
    end

    // Flag LEDs mirror the live flags, one cycle late, with no frame snapshot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_led_flags <= '0;
        else
            o_led_flags <= i_flags;
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt;

    // Halt blink: phase toggles every BLINK_DIV cycles while halted, and restarts lit when halt clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!halt_s) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    // Glyph for the selected digit of the current page, with halt shown as the decimal point.
    always_comb begin
        alu_nib   = digit[2] ? high_s[{digit[1:0], 2'b00} +: 4] : low_s[{digit[1:0], 2'b00} +: 4];
        flag_bits = {3'b000, flags_s};
        glyph     = 8'hFF;
        case (o_page)
            2'd0: glyph = hex_glyph(alu_nib);
            2'd1: glyph = digit == 3'd7 ? hex_glyph(pc_s[7:4]) :
                          digit == 3'd6 ? hex_glyph(pc_s[3:0]) :
                          digit == 3'd5 ? hex_glyph(opcode_s[7:4]) :
                          digit == 3'd4 ? hex_glyph(opcode_s[3:0]) : 8'hFF;
            2'd2: glyph = digit > 3'd4 ? 8'hFF : flag_bits[digit] ? 8'hF9 : 8'hC0;
            default: glyph = digit == 3'd7 ? 8'hC7 :
                             digit == 3'd3 ? (done_s ? 8'hA1 : 8'hBF) :
                             digit == 3'd1 ? hex_glyph(max_addr_s[7:4]) :
                             digit == 3'd0 ? hex_glyph(max_addr_s[3:0]) : 8'hFF;
        endcase
        if (halt_s && o_page != 2'd3)
            glyph[7] = 1'b0;
    end

    // Registered drivers: anode and cathode change together, one cycle after the digit index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg_an  <= 8'hFF;
            o_seg_cat <= 8'hFF;
        end else begin
            o_seg_an  <= blink_off ? 8'hFF : ~(8'd1 << digit);
            o_seg_cat <= glyph;
        end
    end
endmodule

// File: tb/tb_seg_status_display.sv
// tb_seg_status_display: table vectors, corner sequences and randomized pages vs a text-based display model.
module tb_seg_status_display;
    localparam int SD = 4;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  maxa = '0;
    logic        halt = 1'b0;
    logic [15:0] lo = '0;
    logic [15:0] hi = '0;
    logic [4:0]  fl = '0;
    logic [7:0]  op = '0;
    logic [7:0]  pc = '0;
    logic        pnext = 1'b0;
    logic [7:0]  an;
    logic [7:0]  cat;
    logic [1:0]  page;
    logic [4:0]  led;

    seg_status_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_cpu(start), .i_instr_transmit_done(done),
        .i_max_addr(maxa), .i_halt(halt), .i_alu_result_low(lo), .i_alu_result_high(hi),
        .i_flags(fl), .i_current_opcode(op), .i_current_pc(pc), .i_page_next(pnext),
        .o_seg_an(an), .o_seg_cat(cat), .o_page(page), .o_led_flags(led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        done;
        logic [7:0]  maxa;
        logic        halt;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [4:0]  fl;
        logic [7:0]  pc;
        logic [7:0]  op;
        logic [1:0]  pg;
    } vec_t;

    typedef struct packed {
        vec_t        in;
        logic [1:0]  exp_page;
        logic [63:0] exp_cats;
    } tv_t;

    int         checks = 0;
    int         errors = 0;
    int         cur_pg = 0;
    logic [7:0] frame [8];
    tv_t        tv [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic d, input logic [7:0] m, input logic h,
                                input logic [15:0] h16, input logic [15:0] l16, input logic [4:0] f,
                                input logic [7:0] p, input logic [7:0] o, input logic [1:0] g);
        vec_t v;
        v.start = s; v.done = d; v.maxa = m; v.halt = h; v.hi = h16; v.lo = l16;
        v.fl = f; v.pc = p; v.op = o; v.pg = g;
        return v;
    endfunction

    function automatic logic [7:0] glyph_of(input byte c);
        string      hx = "0123456789abcdef";
        logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (c == "L") return 8'hC7;
        if (c == "-") return 8'hBF;
        if (c == " ") return 8'hFF;
        for (int i = 0; i < 16; i++)
            if (hx[i] == c) return tbl[i];
        return 8'h00;
    endfunction

    // Model: render the page as 8 characters, leftmost character is digit 7.
    function automatic logic [7:0] ref_cat(input vec_t v, input int pg, input int d);
        string      s;
        logic [7:0] g;
        case (pg)
            0: s = $sformatf("%04h%04h", v.hi, v.lo);
            1: s = $sformatf("%02h%02h    ", v.pc, v.op);
            2: s = $sformatf("   %05b", v.fl);
            default: s = $sformatf("L   %s %02h", v.done ? "d" : "-", v.maxa);
        endcase
        g = glyph_of(s[7 - d]);
        if (v.halt && pg != 3) g[7] = 1'b0;
        return g;
    endfunction

    task automatic grab_frame(input int ncyc);
        for (int d = 0; d < 8; d++) frame[d] = 8'hxx;
        repeat (ncyc) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++)
                if (an == 8'(~(8'd1 << d))) frame[d] = cat;
        end
    endtask

    task automatic pulse();
        pnext = 1'b1;
        @(negedge clk);
        pnext = 1'b0;
        cur_pg = (cur_pg + 1) % 3;
        check("page_step", 64'(page), 64'(cur_pg));
    endtask

    task automatic apply(input vec_t v);
        done = v.done; maxa = v.maxa; halt = v.halt; hi = v.hi; lo = v.lo;
        fl = v.fl; pc = v.pc; op = v.op; start = v.start;
        @(negedge clk);
        if (!v.start) cur_pg = 0;
        check("page_hold", 64'(page), v.start ? 64'(cur_pg) : 64'd3);
        if (v.start)
            while (cur_pg != int'(v.pg)) pulse();
        repeat (8 * SD + 4) @(negedge clk);
        grab_frame(8 * SD);
        check("led_flags", 64'(led), 64'(v.fl));
    endtask

    task automatic wait_an(input logic [7:0] v);
        int n = 0;
        while (an !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_an", 64'(an), 64'(v));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   ff_cnt;
        int   dp_bad;
        tv[0] = '{mk(0, 1, 8'h3A, 0, 16'h0, 16'h0, 5'h0, 8'h0, 8'h0, 0), 2'd3, 64'hC7FFFFFF_A1FFB088};
        tv[1] = '{mk(0, 0, 8'h00, 0, 16'h0, 16'h0, 5'h0, 8'h0, 8'h0, 0), 2'd3, 64'hC7FFFFFF_BFFFC0C0};
        tv[2] = '{mk(1, 0, 8'h00, 0, 16'h1234, 16'hABCD, 5'h0, 8'h00, 8'h00, 0), 2'd0, 64'hF9A4B099_8883C6A1};
        tv[3] = '{mk(1, 0, 8'h00, 0, 16'h1234, 16'hABCD, 5'h0, 8'h05, 8'h0E, 1), 2'd1, 64'hC092C086_FFFFFFFF};
        tv[4] = '{mk(1, 0, 8'h00, 0, 16'h1234, 16'hABCD, 5'b10110, 8'h05, 8'h0E, 2), 2'd2, 64'hFFFFFFF9_C0F9F9C0};
        tv[5] = '{mk(1, 0, 8'h00, 0, 16'h0000, 16'hFFFF, 5'h0, 8'h00, 8'h00, 0), 2'd0, 64'hC0C0C0C0_8E8E8E8E};

        fl = 5'h1F;
        repeat (3) @(negedge clk);
        check("rst_an", 64'(an), 64'hFF);
        check("rst_cat", 64'(cat), 64'hFF);
        check("rst_page", 64'(page), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8 * SD + 4; k++) begin
            @(negedge clk);
            check($sformatf("scan_an_%0d", k), 64'(an), 64'(8'(~(8'd1 << ((k / SD) % 8)))));
        end
        check("led_live", 64'(led), 64'h1F);

        for (int i = 0; i < 6; i++) begin
            apply(tv[i].in);
            check($sformatf("tv%0d_page", i), 64'(page), 64'(tv[i].exp_page));
            for (int d = 0; d < 8; d++)
                check($sformatf("tv%0d_dig%0d", i, d), 64'(frame[d]), 64'(tv[i].exp_cats[d * 8 +: 8]));
        end

        lo = 16'h1111;
        repeat (8 * SD + 4) @(negedge clk);
        wait_an(8'hF7);
        lo = 16'h2222;
        check("mid_old_dig3", 64'(cat), 64'hF9);
        wait_an(8'hFE);
        check("mid_new_dig0", 64'(cat), 64'hA4);
        wait_an(8'hF7);
        check("mid_new_dig3", 64'(cat), 64'hA4);

        pulse();
        start = 1'b0;
        pnext = 1'b1;
        @(negedge clk);
        pnext = 1'b0;
        cur_pg = 0;
        check("fall_ignores_pulse", 64'(page), 64'd3);
        start = 1'b1;
        @(negedge clk);
        check("start_rise_page0", 64'(page), 64'd0);
        @(negedge clk);
        check("start_rise_hold", 64'(page), 64'd0);

        halt = 1'b1;
        repeat (8 * SD + 4) @(negedge clk);
        ff_cnt = 0;
        dp_bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (an == 8'hFF) ff_cnt++;
            else if (cat[7] !== 1'b0) dp_bad++;
        end
        check("halt_dp", 64'(dp_bad), 64'd0);
`ifdef DISPLAY_BLINK_EN
        check("halt_blink_off_cycles", 64'(ff_cnt), 64'd32);
`else
        check("halt_no_blank", 64'(ff_cnt), 64'd0);
`endif
        halt = 1'b0;
        repeat (8 * SD + 4) @(negedge clk);
        ff_cnt = 0;
        dp_bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (an == 8'hFF) ff_cnt++;
            else if (cat[7] !== 1'b1) dp_bad++;
        end
        check("unhalt_dp", 64'(dp_bad), 64'd0);
        check("unhalt_lit", 64'(ff_cnt), 64'd0);

        for (int r = 0; r < 20; r++) begin
            v.start = $urandom_range(0, 3) != 0;
            v.done  = 1'($urandom);
            v.maxa  = 8'($urandom);
`ifdef DISPLAY_BLINK_EN
            v.halt  = 1'b0;
`else
            v.halt  = 1'($urandom);
`endif
            v.hi    = 16'($urandom);
            v.lo    = 16'($urandom);
            v.fl    = 5'($urandom);
            v.pc    = 8'($urandom);
            v.op    = 8'($urandom);
            v.pg    = 2'($urandom_range(0, 2));
            apply(v);
            for (int d = 0; d < 8; d++)
                check($sformatf("rnd%0d_dig%0d", r, d), 64'(frame[d]),
                      64'(ref_cat(v, v.start ? cur_pg : 3, d)));
        end

        fl = 5'h15;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 64'(an), 64'hFF);
        check("async_rst_cat", 64'(cat), 64'hFF);
        check("async_rst_page", 64'(page), 64'd0);
        check("async_rst_led", 64'(led), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
